// File: rtl/main_top.sv
// main_top: SPI-slave command front end for the host MCU.
// Receives 64-bit frames (four 16-bit words, MSB first, SPI mode 0) and
// latches them into cmd/param/x/y registers on a valid frame end. The
// previous valid frame is echoed back on MISO. It also drives a status LED
// that toggles per valid frame, ORed with the pushbutton.
//
// Ports:
//   clock        system clock
//   reset        synchronous active-high reset
//   io_aresetn   board reset button, active-low, asynchronous
//   io_btn       pushbutton, asynchronous, active-high
//   io_led       status LED
//   io_spi_sclk  SPI clock (mode 0), asynchronous, oversampled
//   io_spi_cs    SPI chip select, active-low, asynchronous
//   io_spi_mosi  SPI data in, MSB first
//   io_spi_miso  SPI data out, MSB first
module main_top #(
  parameter int unsigned FRAME_BITS  = 64,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic io_aresetn,
  input  logic io_btn,
  output logic io_led,
  input  logic io_spi_sclk,
  input  logic io_spi_cs,
  input  logic io_spi_mosi,
  output logic io_spi_miso
);

  localparam int unsigned W         = FRAME_BITS;
  localparam logic [6:0]  FRAME_LEN = 7'(FRAME_BITS);

  typedef enum logic {IDLE, XFER} state_t;

  // Synchronizer chains for all asynchronous pins, packed as
  // {aresetn, btn, mosi, cs, sclk}. Left unreset so the board reset button
  // can itself be synchronized before it feeds the internal reset.
  logic [4:0] pins;
  logic [4:0] sync_q [SYNC_STAGES];
  logic [4:0] pins_s;

  assign pins   = {io_aresetn, io_btn, io_spi_mosi, io_spi_cs, io_spi_sclk};
  assign pins_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clock) begin
    sync_q[0] <= pins;
    for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
      sync_q[i] <= sync_q[i-1];
    end
  end

  logic sclk_s, cs_s, mosi_s, btn_s, aresetn_s;
  assign sclk_s    = pins_s[0];
  assign cs_s      = pins_s[1];
  assign mosi_s    = pins_s[2];
  assign btn_s     = pins_s[3];
  assign aresetn_s = pins_s[4];

  logic rst;
  assign rst = reset | ~aresetn_s;

  state_t      state_q, state_d;
  logic        sclk_prev_q;
  logic        cs_prev_q;
  logic [6:0]  bit_cnt_q, bit_cnt_d;
  logic [W-1:0] shift_in_q, shift_in_d;
  logic [W-1:0] shift_out_q, shift_out_d;
  logic [W-1:0] echo_q, echo_d;
  logic [15:0] cmd_q, cmd_d;
  logic [15:0] param_q, param_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        led_q, led_d;
  logic        miso_q, miso_d;

  logic sclk_rise, sclk_fall, cs_fall, cs_rise;
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  // cs_prev resets to 0: a cs already low when reset releases is not seen as
  // a falling edge, so an aborted frame cannot resume mid-way.
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_in_d  = shift_in_q;
    shift_out_d = shift_out_q;
    echo_d      = echo_q;
    cmd_d       = cmd_q;
    param_d     = param_q;
    x_d         = x_q;
    y_d         = y_q;
    frame_cnt_d = frame_cnt_q;
    led_d       = led_q;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d     = XFER;
          bit_cnt_d   = '0;
          shift_in_d  = '0;
          shift_out_d = echo_q;
        end
      end
      XFER: begin
        if (sclk_rise) begin
          if (bit_cnt_q < FRAME_LEN) begin
            shift_in_d = {shift_in_q[W-2:0], mosi_s};
          end
          if (bit_cnt_q != 7'h7F) begin
            bit_cnt_d = bit_cnt_q + 7'd1;
          end
        end
        if (sclk_fall) begin
          shift_out_d = {shift_out_q[W-2:0], 1'b0};
        end
        // The valid-frame check looks at the post-shift values so a final
        // SCLK rise landing in the same clock as the cs rise still counts.
        if (cs_rise) begin
          state_d = IDLE;
          if (bit_cnt_d >= FRAME_LEN) begin
            cmd_d       = shift_in_d[W-1  -: 16];
            param_d     = shift_in_d[W-17 -: 16];
            x_d         = shift_in_d[W-33 -: 16];
            y_d         = shift_in_d[W-49 -: 16];
            echo_d      = shift_in_d;
            frame_cnt_d = frame_cnt_q + 16'd1;
            led_d       = ~led_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    miso_d = (state_q == XFER) ? shift_out_q[W-1] : 1'b0;
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      bit_cnt_q   <= '0;
      shift_in_q  <= '0;
      shift_out_q <= '0;
      echo_q      <= '0;
      cmd_q       <= '0;
      param_q     <= '0;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
      led_q       <= 1'b0;
      miso_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      bit_cnt_q   <= bit_cnt_d;
      shift_in_q  <= shift_in_d;
      shift_out_q <= shift_out_d;
      echo_q      <= echo_d;
      cmd_q       <= cmd_d;
      param_q     <= param_d;
      x_q         <= x_d;
      y_q         <= y_d;
      frame_cnt_q <= frame_cnt_d;
      led_q       <= led_d;
      miso_q      <= miso_d;
    end
  end

  assign io_led      = led_q | btn_s;
  assign io_spi_miso = miso_q;

endmodule

// File: tb/tb_main_top.sv
// Directed bench for main_top: drives SPI frames bit by bit and checks the
// decoded registers, frame counter, LED and the echoed MISO stream.
module tb_main_top;

  logic clock = 1'b0;
  logic reset, io_aresetn, io_btn, io_led;
  logic io_spi_sclk, io_spi_cs, io_spi_mosi, io_spi_miso;

  int vectors = 0;
  int errors  = 0;
  logic [127:0] miso_cap;

  always #5 clock = ~clock;

  main_top #(.FRAME_BITS(64), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_aresetn (io_aresetn),
    .io_btn     (io_btn),
    .io_led     (io_led),
    .io_spi_sclk(io_spi_sclk),
    .io_spi_cs  (io_spi_cs),
    .io_spi_mosi(io_spi_mosi),
    .io_spi_miso(io_spi_miso)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Shifts d[n-1:0] out MSB first at a 500 ns SCLK period; MISO is captured
  // just before each rising edge, as a mode-0 master would.
  task automatic send_bits(input logic [127:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      io_spi_mosi = d[i];
      #125;
      miso_cap = {miso_cap[126:0], io_spi_miso};
      #125 io_spi_sclk = 1'b1;
      #250 io_spi_sclk = 1'b0;
    end
  endtask

  task automatic cs_low();
    miso_cap  = '0;
    io_spi_cs = 1'b0;
    #250;
  endtask

  task automatic cs_high();
    #250 io_spi_cs = 1'b1;
    #200;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; io_aresetn = 1'b0; io_btn = 1'b0;
    io_spi_sclk = 1'b0; io_spi_cs = 1'b1; io_spi_mosi = 1'b0;
    miso_cap = '0;

    // Reset
    repeat (10) @(posedge clock);
    #1;
    check("rst_led",       64'(io_led), 64'd0);
    check("rst_miso",      64'(io_spi_miso), 64'd0);
    check("rst_frame_cnt", 64'(dut.frame_cnt_q), 64'd0);
    check("rst_x",         64'(dut.x_q), 64'd0);
    @(negedge clock);
    reset = 1'b0; io_aresetn = 1'b1;
    repeat (6) @(negedge clock);

    // Frame 1: exactly 64 bits
    cs_low();
    send_bits(128'h0000_0000_0064_0064, 64);
    cs_high();
    check("f1_x",         64'(dut.x_q), 64'd100);
    check("f1_y",         64'(dut.y_q), 64'd100);
    check("f1_cmd",       64'(dut.cmd_q), 64'd0);
    check("f1_param",     64'(dut.param_q), 64'd0);
    check("f1_frame_cnt", 64'(dut.frame_cnt_q), 64'd1);
    check("f1_led",       64'(io_led), 64'd1);
    check("f1_miso_echo", miso_cap[63:0], 64'd0);
    check("f1_miso_idle", 64'(io_spi_miso), 64'd0);

    // Frame 2: same payload plus two trailing zero bits (66 bits)
    cs_low();
    send_bits(128'h0000_0000_0064_0064 << 2, 66);
    cs_high();
    check("f2_x",         64'(dut.x_q), 64'd100);
    check("f2_y",         64'(dut.y_q), 64'd100);
    check("f2_frame_cnt", 64'(dut.frame_cnt_q), 64'd2);
    check("f2_led",       64'(io_led), 64'd0);
    check("f2_miso_echo", miso_cap[65:2], 64'h0000_0000_0064_0064);
    check("f2_miso_tail", 64'(miso_cap[1:0]), 64'd0);

    // Short frame: 40 bits, must be discarded
    cs_low();
    send_bits(128'hFF_FFFF_FFFF, 40);
    cs_high();
    check("sh_x",         64'(dut.x_q), 64'd100);
    check("sh_cmd",       64'(dut.cmd_q), 64'd0);
    check("sh_frame_cnt", 64'(dut.frame_cnt_q), 64'd2);
    check("sh_led",       64'(io_led), 64'd0);

    // Button
    @(negedge clock) io_btn = 1'b1;
    repeat (3) @(posedge clock);
    #1 check("btn_press", 64'(io_led), 64'd1);
    @(negedge clock) io_btn = 1'b0;
    repeat (3) @(posedge clock);
    #1 check("btn_release", 64'(io_led), 64'd0);

    // Mid-frame reset after 30 bits; frame completed without toggling cs
    cs_low();
    send_bits(128'h0000_0000_0064_0064 >> 34, 30);
    @(negedge clock) io_aresetn = 1'b0;
    repeat (4) @(negedge clock);
    io_aresetn = 1'b1;
    send_bits(128'h0000_0000_0064_0064 & 128'h3_FFFF_FFFF, 34);
    cs_high();
    check("mr_x",         64'(dut.x_q), 64'd0);
    check("mr_y",         64'(dut.y_q), 64'd0);
    check("mr_frame_cnt", 64'(dut.frame_cnt_q), 64'd0);
    check("mr_led",       64'(io_led), 64'd0);
    check("mr_echo",      dut.echo_q, 64'd0);

    // Fresh frame after the aborted one decodes all four words
    cs_low();
    send_bits(128'h1234_5678_9ABC_DEF0, 64);
    cs_high();
    check("nf_cmd",       64'(dut.cmd_q), 64'h1234);
    check("nf_param",     64'(dut.param_q), 64'h5678);
    check("nf_x",         64'(dut.x_q), 64'h9ABC);
    check("nf_y",         64'(dut.y_q), 64'hDEF0);
    check("nf_frame_cnt", 64'(dut.frame_cnt_q), 64'd1);
    check("nf_led",       64'(io_led), 64'd1);
    check("nf_miso_echo", miso_cap[63:0], 64'd0);

    // Echo of the decoded frame on the next transfer
    cs_low();
    send_bits(128'h0, 64);
    cs_high();
    check("ec_miso_echo", miso_cap[63:0], 64'h1234_5678_9ABC_DEF0);
    check("ec_frame_cnt", 64'(dut.frame_cnt_q), 64'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
